// File: rtl/ps2_key_queue.sv
// PS/2 set-2 scan-code decoder feeding a first-word-fall-through event FIFO.
// Events are {break, extended, code}; held-key typematic repeats can be filtered out.
module ps2_key_queue #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter bit DROP_REPEAT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [9:0]    key_out,
    output logic          key_valid,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK
    } dec_state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

    dec_state_t      state_reg;
    logic [8:0]      last_make_reg;
    logic            last_valid_reg;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW:0]     count_reg;
    logic [AW:0]     count_next;
    logic [9:0]      head_reg;
    logic [9:0]      head_next;
    logic            overflow_reg;

    logic            is_e0;
    logic            is_f0;
    logic            is_noise;
    logic            emit;
    logic [9:0]      event_word;
    logic            is_repeat;
    logic            push_req;
    logic            empty;
    logic            full;
    logic            pop_ok;
    logic            push_ok;
    logic            overflow_set;
    logic [AW-1:0]   rd_ptr_inc;

    assign is_e0    = (byte_in == 8'hE0);
    assign is_f0    = (byte_in == 8'hF0);
    // Controller replies (BAT pass, ACK, echo, resend) and error bytes only matter outside a prefix.
    assign is_noise = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hEE) ||
                      (byte_in == 8'hFE) || (byte_in == 8'h00);

    always_comb begin
        emit       = 1'b0;
        event_word = {2'b00, byte_in};
        if (byte_valid && !is_e0 && !is_f0) begin
            case (state_reg)
                IDLE: begin
                    emit       = !is_noise;
                    event_word = {2'b00, byte_in};
                end
                EXT: begin
                    emit       = 1'b1;
                    event_word = {2'b01, byte_in};
                end
                BRK: begin
                    emit       = 1'b1;
                    event_word = {2'b10, byte_in};
                end
                default: begin
                    emit       = 1'b1;
                    event_word = {2'b11, byte_in};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else if (byte_valid) begin
            case (state_reg)
                IDLE:    state_reg <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                EXT:     state_reg <= is_f0 ? EXTBRK : (is_e0 ? EXT : IDLE);
                BRK:     state_reg <= is_e0 ? EXTBRK : (is_f0 ? BRK : IDLE);
                default: state_reg <= (is_e0 || is_f0) ? EXTBRK : IDLE;
            endcase
        end
    end

    assign is_repeat = DROP_REPEAT && !event_word[9] && last_valid_reg &&
                       (event_word[8:0] == last_make_reg);
    assign push_req  = emit && !is_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_make_reg  <= '0;
            last_valid_reg <= 1'b0;
        end else if (emit) begin
            if (!event_word[9]) begin
                if (!is_repeat) begin
                    last_make_reg  <= event_word[8:0];
                    last_valid_reg <= 1'b1;
                end
            end else if (event_word[8:0] == last_make_reg) begin
                last_valid_reg <= 1'b0;
            end
        end
    end

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == FULL_COUNT);
    assign pop_ok       = rd_en && !empty;
    assign push_ok      = push_req && (!full || pop_ok);
    assign overflow_set = push_req && full && !pop_ok;
    assign rd_ptr_inc   = rd_ptr_reg + 1'b1;

    always_comb begin
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + ONE_COUNT;
            2'b01:   count_next = count_reg - ONE_COUNT;
            default: count_next = count_reg;
        endcase
    end

    // The head is kept in its own register so key_out is a clean flop output.
    always_comb begin
        head_next = head_reg;
        if (count_next == '0) begin
            head_next = '0;
        end else if (empty || (pop_ok && count_reg == ONE_COUNT)) begin
            head_next = event_word;
        end else if (pop_ok) begin
            head_next = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= event_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            head_reg  <= head_next;
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign key_out   = head_reg;
    assign key_valid = !empty;
    assign count     = count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed bench for ps2_key_queue: decoder prefixes, repeat filter, FIFO limits, reset.
module tb_ps2_key_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       rd_en;
    logic       clr_ovf;
    logic [9:0] key_out;
    logic       key_valid;
    logic [3:0] count;
    logic       overflow;
    logic [9:0] nr_key_out;
    logic       nr_key_valid;
    logic [3:0] nr_count;
    logic       nr_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_queue #(.DEPTH(8), .AW(3), .DROP_REPEAT(1'b1)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .key_out(key_out), .key_valid(key_valid),
        .count(count), .overflow(overflow)
    );

    ps2_key_queue #(.DEPTH(8), .AW(3), .DROP_REPEAT(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .key_out(nr_key_out), .key_valid(nr_key_valid),
        .count(nr_count), .overflow(nr_overflow)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] fill_codes [9];
    logic [7:0] tail_codes [8];

    initial begin
        fill_codes = '{8'h15, 8'h16, 8'h1C, 8'h1D, 8'h1E, 8'h21, 8'h22, 8'h23, 8'h24};
        tail_codes = '{8'h16, 8'h1C, 8'h1D, 8'h1E, 8'h21, 8'h22, 8'h23, 8'h24};
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_key_out", 16'(key_out), 16'h000);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_count", 16'(count), 16'h0);
        check("rst_overflow", 16'(overflow), 16'h0);

        // Plain make code, latency one clock
        send(8'h1D);
        check("make_key", 16'(key_out), 16'h01D);
        check("make_valid", 16'(key_valid), 16'h1);
        check("make_count", 16'(count), 16'h1);
        pop();
        check("pop_valid", 16'(key_valid), 16'h0);
        check("pop_key", 16'(key_out), 16'h000);
        pop();
        check("underflow_count", 16'(count), 16'h0);

        send(8'hF0); send(8'h1D);
        check("break_key", 16'(key_out), 16'h21D);
        pop();
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_break_key", 16'(key_out), 16'h375);
        pop();
        send(8'hE0); send(8'h75);
        check("ext_make_key", 16'(key_out), 16'h175);
        pop();

        // Typematic filter vs unfiltered instance
        do_reset();
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1D);
        check("filt_count", 16'(count), 16'h3);
        check("nofilt_count", 16'(nr_count), 16'h5);
        check("filt_head0", 16'(key_out), 16'h01D);
        pop();
        check("filt_head1", 16'(key_out), 16'h21D);
        pop();
        check("filt_head2", 16'(key_out), 16'h01D);
        pop();
        check("filt_empty", 16'(count), 16'h0);

        // Overflow: nine pushes into eight entries
        do_reset();
        for (int i = 0; i < 9; i++) send(fill_codes[i]);
        check("full_count", 16'(count), 16'h8);
        check("ovf_set", 16'(overflow), 16'h1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop%0d", i), 16'(key_out), {8'h00, fill_codes[i]});
            pop();
        end
        check("drained_count", 16'(count), 16'h0);
        check("ovf_sticky", 16'(overflow), 16'h1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        check("ovf_cleared", 16'(overflow), 16'h0);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < 8; i++) send(fill_codes[i]);
        check("full8_count", 16'(count), 16'h8);
        @(negedge clk);
        byte_in = 8'h24; byte_valid = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; rd_en = 1'b0;
        check("pp_count", 16'(count), 16'h8);
        check("pp_overflow", 16'(overflow), 16'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_pop%0d", i), 16'(key_out), {8'h00, tail_codes[i]});
            pop();
        end
        check("pp_empty", 16'(key_valid), 16'h0);

        // Reset discards a pending E0 prefix
        send(8'hE0);
        do_reset();
        check("rst_mid_valid", 16'(key_valid), 16'h0);
        send(8'h6B);
        check("rst_mid_key", 16'(key_out), 16'h06B);
        pop();
        send(8'hAA); send(8'hFA);
        check("noise_count", 16'(count), 16'h0);
        check("noise_valid", 16'(key_valid), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
